// File: rtl/pid_error_gen.sv
// Attitude P/I/D error generator: one axis per cycle through a shared datapath, publish at PUB.
// Define PID_ERR_DFILT_EN to low-pass the derivative terms (d_f += (d - d_f) >>> 2).
module pid_error_gen #(
  parameter logic signed [23:0] I_LIMIT  = 24'sd100000,
  parameter logic signed [23:0] YAW_HALF = 24'sd18000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               meas_valid,
  input  logic               i_clr,
  input  logic signed [23:0] set_pitch,
  input  logic signed [23:0] set_roll,
  input  logic signed [23:0] set_yaw,
  input  logic signed [23:0] meas_pitch,
  input  logic signed [23:0] meas_roll,
  input  logic signed [23:0] meas_yaw,
  output logic signed [23:0] pitch_error,
  output logic signed [23:0] roll_error,
  output logic signed [23:0] yaw_error,
  output logic signed [23:0] i_pitch_error,
  output logic signed [23:0] i_roll_error,
  output logic signed [23:0] i_yaw_error,
  output logic signed [23:0] d_pitch_error,
  output logic signed [23:0] d_roll_error,
  output logic signed [23:0] d_yaw_error,
  output logic               cal_pid_en,
  output logic               overrun
);

  typedef enum logic [2:0] {IDLE, PITCH, ROLL, YAW, PUB} state_t;

  localparam logic signed [25:0] MAX24 = 26'sd8388607;
  localparam logic signed [25:0] MIN24 = -26'sd8388608;
  localparam logic signed [25:0] ILIM  = {{2{I_LIMIT[23]}}, I_LIMIT};
  localparam logic signed [25:0] YH    = {{2{YAW_HALF[23]}}, YAW_HALF};

  function automatic logic signed [25:0] sx(input logic signed [23:0] v);
    return {{2{v[23]}}, v};
  endfunction

  function automatic logic signed [23:0] sat24(input logic signed [25:0] v);
    if (v > MAX24)      return MAX24[23:0];
    else if (v < MIN24) return MIN24[23:0];
    else                return v[23:0];
  endfunction

  state_t             state_q, state_d;
  logic signed [23:0] set_q [3], set_d [3];
  logic signed [23:0] meas_q [3], meas_d [3];
  logic signed [23:0] sh_p_q [3], sh_p_d [3];
  logic signed [23:0] sh_i_q [3], sh_i_d [3];
  logic signed [23:0] sh_d_q [3], sh_d_d [3];
  logic signed [23:0] i_acc_q [3], i_acc_d [3];
  logic signed [23:0] e_prev_q [3], e_prev_d [3];
  logic signed [23:0] p_out_q [3], p_out_d [3];
  logic signed [23:0] i_out_q [3], i_out_d [3];
  logic signed [23:0] d_out_q [3], d_out_d [3];
  logic               first_q, first_d;
  logic               cal_en_q, cal_en_d;
  logic               overrun_q, overrun_d;
`ifdef PID_ERR_DFILT_EN
  logic signed [23:0] df_q [3], df_d [3];
  logic signed [25:0] d_diff, d_sum;
`endif

  logic [1:0]         ax;
  logic signed [25:0] e_full, i_sum;
  logic signed [23:0] e_ax, i_ax, d_raw, d_ax;

  // Shared per-axis datapath, steered by the current FSM state.
  always_comb begin
    case (state_q)
      ROLL:    ax = 2'd1;
      YAW:     ax = 2'd2;
      default: ax = 2'd0;
    endcase
    e_full = sx(set_q[ax]) - sx(meas_q[ax]);
    if (state_q == YAW) begin
      if (e_full >= YH)       e_full = e_full - (YH + YH);
      else if (e_full < -YH)  e_full = e_full + (YH + YH);
    end
    e_ax  = sat24(e_full);
    i_sum = sx(i_acc_q[ax]) + sx(e_ax);
    if (i_sum > ILIM)       i_ax = I_LIMIT;
    else if (i_sum < -ILIM) i_ax = -I_LIMIT;
    else                    i_ax = i_sum[23:0];
    d_raw = first_q ? '0 : sat24(sx(e_ax) - sx(e_prev_q[ax]));
`ifdef PID_ERR_DFILT_EN
    d_diff = sx(d_raw) - sx(df_q[ax]);
    d_sum  = sx(df_q[ax]) + (d_diff >>> 2);
    d_ax   = d_sum[23:0];
`else
    d_ax   = d_raw;
`endif
  end

  always_comb begin
    state_d   = state_q;
    set_d     = set_q;
    meas_d    = meas_q;
    sh_p_d    = sh_p_q;
    sh_i_d    = sh_i_q;
    sh_d_d    = sh_d_q;
    i_acc_d   = i_acc_q;
    e_prev_d  = e_prev_q;
    p_out_d   = p_out_q;
    i_out_d   = i_out_q;
    d_out_d   = d_out_q;
    first_d   = first_q;
    cal_en_d  = 1'b0;
    overrun_d = 1'b0;
`ifdef PID_ERR_DFILT_EN
    df_d      = df_q;
`endif
    if (i_clr) begin
      // Abort: loop state is reset, published outputs are left alone.
      state_d = IDLE;
      first_d = 1'b1;
      for (int k = 0; k < 3; k++) begin
        i_acc_d[k]  = '0;
        e_prev_d[k] = '0;
`ifdef PID_ERR_DFILT_EN
        df_d[k]     = '0;
`endif
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (meas_valid) begin
            set_d[0]  = set_pitch;
            set_d[1]  = set_roll;
            set_d[2]  = set_yaw;
            meas_d[0] = meas_pitch;
            meas_d[1] = meas_roll;
            meas_d[2] = meas_yaw;
            state_d   = PITCH;
          end
        end
        PITCH, ROLL, YAW: begin
          sh_p_d[ax] = e_ax;
          sh_i_d[ax] = i_ax;
          sh_d_d[ax] = d_ax;
          overrun_d  = meas_valid;
          state_d    = (state_q == PITCH) ? ROLL : (state_q == ROLL) ? YAW : PUB;
        end
        PUB: begin
          p_out_d   = sh_p_q;
          i_out_d   = sh_i_q;
          d_out_d   = sh_d_q;
          i_acc_d   = sh_i_q;
          e_prev_d  = sh_p_q;
`ifdef PID_ERR_DFILT_EN
          df_d      = sh_d_q;
`endif
          first_d   = 1'b0;
          cal_en_d  = 1'b1;
          overrun_d = meas_valid;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      first_q   <= 1'b1;
      cal_en_q  <= 1'b0;
      overrun_q <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        set_q[k]    <= '0;
        meas_q[k]   <= '0;
        sh_p_q[k]   <= '0;
        sh_i_q[k]   <= '0;
        sh_d_q[k]   <= '0;
        i_acc_q[k]  <= '0;
        e_prev_q[k] <= '0;
        p_out_q[k]  <= '0;
        i_out_q[k]  <= '0;
        d_out_q[k]  <= '0;
`ifdef PID_ERR_DFILT_EN
        df_q[k]     <= '0;
`endif
      end
    end else begin
      state_q   <= state_d;
      first_q   <= first_d;
      cal_en_q  <= cal_en_d;
      overrun_q <= overrun_d;
      set_q     <= set_d;
      meas_q    <= meas_d;
      sh_p_q    <= sh_p_d;
      sh_i_q    <= sh_i_d;
      sh_d_q    <= sh_d_d;
      i_acc_q   <= i_acc_d;
      e_prev_q  <= e_prev_d;
      p_out_q   <= p_out_d;
      i_out_q   <= i_out_d;
      d_out_q   <= d_out_d;
`ifdef PID_ERR_DFILT_EN
      df_q      <= df_d;
`endif
    end
  end

  assign pitch_error   = p_out_q[0];
  assign roll_error    = p_out_q[1];
  assign yaw_error     = p_out_q[2];
  assign i_pitch_error = i_out_q[0];
  assign i_roll_error  = i_out_q[1];
  assign i_yaw_error   = i_out_q[2];
  assign d_pitch_error = d_out_q[0];
  assign d_roll_error  = d_out_q[1];
  assign d_yaw_error   = d_out_q[2];
  assign cal_pid_en    = cal_en_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_pid_error_gen.sv
// Directed bench for pid_error_gen: vector table of runs plus overrun, clear and reset sequences.
module tb_pid_error_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, meas_valid, i_clr;
  logic signed [23:0] set_p, set_r, set_y, meas_p, meas_r, meas_y;
  logic signed [23:0] pe, re, ye, ipe, ire, iye, dpe, dre, dye;
  logic cal_pid_en, overrun;

  int checks = 0;
  int errors = 0;

  pid_error_gen dut (
    .clk(clk), .rst(rst), .meas_valid(meas_valid), .i_clr(i_clr),
    .set_pitch(set_p), .set_roll(set_r), .set_yaw(set_y),
    .meas_pitch(meas_p), .meas_roll(meas_r), .meas_yaw(meas_y),
    .pitch_error(pe), .roll_error(re), .yaw_error(ye),
    .i_pitch_error(ipe), .i_roll_error(ire), .i_yaw_error(iye),
    .d_pitch_error(dpe), .d_roll_error(dre), .d_yaw_error(dye),
    .cal_pid_en(cal_pid_en), .overrun(overrun)
  );

  typedef struct {
    bit clr;
    int sp, sr, sy, mp, mr, my;
    int ep, er, ey, ip, ir, iy, dp, dr, dy;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_in(input int sp, input int sr, input int sy, input int mp, input int mr, input int my);
    set_p = 24'(sp); set_r = 24'(sr); set_y = 24'(sy);
    meas_p = 24'(mp); meas_r = 24'(mr); meas_y = 24'(my);
  endtask

  // Drives meas_valid/i_clr on chosen cycles for a fixed 20-cycle window and counts strobes.
  task automatic run_sched(input int c1, input int c2, input int clr_at,
                           output int n_cal, output int n_ovr, output int f_cal, output int f_ovr);
    n_cal = 0; n_ovr = 0; f_cal = -1; f_ovr = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cal_pid_en === 1'b1) begin n_cal++; if (f_cal < 0) f_cal = i; end
      if (overrun === 1'b1) begin n_ovr++; if (f_ovr < 0) f_ovr = i; end
      meas_valid = (i == c1) || (i == c2);
      i_clr      = (i == clr_at);
    end
    meas_valid = 1'b0;
    i_clr      = 1'b0;
  endtask

  task automatic chk_out(input string tag, input vec_t v);
    chk({tag, " p_pitch"}, $signed(pe),  v.ep);
    chk({tag, " p_roll"},  $signed(re),  v.er);
    chk({tag, " p_yaw"},   $signed(ye),  v.ey);
    chk({tag, " i_pitch"}, $signed(ipe), v.ip);
    chk({tag, " i_roll"},  $signed(ire), v.ir);
    chk({tag, " i_yaw"},   $signed(iye), v.iy);
    chk({tag, " d_pitch"}, $signed(dpe), v.dp);
    chk({tag, " d_roll"},  $signed(dre), v.dr);
    chk({tag, " d_yaw"},   $signed(dye), v.dy);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int n_cal, n_ovr, f_cal, f_ovr;
    if (v.clr) begin
      @(negedge clk); i_clr = 1'b1;
      @(negedge clk); i_clr = 1'b0;
    end
    set_in(v.sp, v.sr, v.sy, v.mp, v.mr, v.my);
    run_sched(0, -1, -1, n_cal, n_ovr, f_cal, f_ovr);
    chk({tag, " cal_count"}, n_cal, 1);
    chk({tag, " cal_latency"}, f_cal, 5);
    chk({tag, " overrun_count"}, n_ovr, 0);
    chk_out(tag, v);
  endtask

  initial begin
    int n_cal, n_ovr, f_cal, f_ovr;
    vec_t pre, post;

    vt[0]  = '{0, 100, 200, 300, 0, 0, 0, 100, 200, 300, 100, 200, 300, 0, 0, 0};
    vt[1]  = '{0, 100, 200, 300, 0, 0, 0, 100, 200, 300, 200, 400, 600, 0, 0, 0};
    vt[2]  = '{0, 150, 200, 300, 0, 0, 0, 150, 200, 300, 350, 600, 900, 50, 0, 0};
    vt[3]  = '{1, 0, 0, 17000, 0, 0, -17000, 0, 0, -2000, 0, 0, -2000, 0, 0, 0};
    vt[4]  = '{0, 0, 0, -17000, 0, 0, 17000, 0, 0, 2000, 0, 0, 0, 0, 0, 4000};
    vt[5]  = '{1, 60000, 0, 0, 0, 0, 0, 60000, 0, 0, 60000, 0, 0, 0, 0, 0};
    vt[6]  = '{0, 60000, 0, 0, 0, 0, 0, 60000, 0, 0, 100000, 0, 0, 0, 0, 0};
    vt[7]  = '{0, 60000, 0, 0, 0, 0, 0, 60000, 0, 0, 100000, 0, 0, 0, 0, 0};
    vt[8]  = '{0, -300000, 0, 0, 0, 0, 0, -300000, 0, 0, -100000, 0, 0, -360000, 0, 0};
    vt[9]  = '{1, 8388607, 0, 0, -8388608, 0, 0, 8388607, 0, 0, 100000, 0, 0, 0, 0, 0};
    vt[10] = '{0, -8388608, 0, 0, 8388607, 0, 0, -8388608, 0, 0, -100000, 0, 0, -8388608, 0, 0};
    vt[11] = '{1, 0, 0, 18000, 0, 0, 0, 0, 0, -18000, 0, 0, -18000, 0, 0, 0};
    vt[12] = '{0, 0, 0, 0, 0, 0, 18000, 0, 0, -18000, 0, 0, -36000, 0, 0, 0};

    meas_valid = 1'b0;
    i_clr      = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset p_pitch", $signed(pe), 0);
    chk("reset i_yaw", $signed(iye), 0);
    chk("reset d_roll", $signed(dre), 0);
    chk("reset cal_pid_en", cal_pid_en, 0);
    chk("reset overrun", overrun, 0);
    rst = 1'b0;

    for (int k = 0; k < 13; k++) run_vec($sformatf("vec%0d", k), vt[k]);

    // Clear in the middle of a run, with a simultaneous strobe: nothing published, no overrun.
    set_in(500, 0, 0, 0, 0, 0);
    run_sched(0, 2, 2, n_cal, n_ovr, f_cal, f_ovr);
    chk("clr cal_count", n_cal, 0);
    chk("clr overrun_count", n_ovr, 0);
    chk_out("clr held", vt[12]);
    post = '{0, 700, 0, 0, 0, 0, 0, 700, 0, 0, 700, 0, 0, 0, 0, 0};
    run_vec("after_clr", post);

    run_sched(0, 2, -1, n_cal, n_ovr, f_cal, f_ovr);
    chk("ovr2 cal_count", n_cal, 1);
    chk("ovr2 overrun_count", n_ovr, 1);
    chk("ovr2 overrun_cycle", f_ovr, 3);
    run_sched(0, 5, -1, n_cal, n_ovr, f_cal, f_ovr);
    chk("gap5 cal_count", n_cal, 2);
    chk("gap5 overrun_count", n_ovr, 0);
    run_sched(0, 4, -1, n_cal, n_ovr, f_cal, f_ovr);
    chk("gap4 cal_count", n_cal, 1);
    chk("gap4 overrun_count", n_ovr, 1);
    chk("gap4 overrun_cycle", f_ovr, 5);

    // Reset while the ROLL axis is being computed.
    pre = '{1, 400, 0, 0, 0, 0, 0, 400, 0, 0, 400, 0, 0, 0, 0, 0};
    run_vec("pre_rst", pre);
    set_in(1000, 0, 0, 0, 0, 0);
    @(negedge clk); meas_valid = 1'b1;
    @(negedge clk); meas_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1;
    chk("midrst p_pitch", $signed(pe), 0);
    chk("midrst i_pitch", $signed(ipe), 0);
    chk("midrst cal_pid_en", cal_pid_en, 0);
    @(negedge clk); rst = 1'b0;
    n_cal = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cal_pid_en === 1'b1) n_cal++;
    end
    chk("midrst no_strobe", n_cal, 0);
    post = '{0, 1000, 0, 0, 0, 0, 0, 1000, 0, 0, 1000, 0, 0, 0, 0, 0};
    run_vec("post_rst", post);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
